// File: rtl/conv_accel_feeder.sv
// rtl/conv_accel_feeder.sv - loads one pixel frame into the convolution accelerator FIFO, starts it and collects its results
module conv_accel_feeder #(
    parameter int BIT_LEN = 16,
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int OUT_N   = 676
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               go,
    input  logic [BIT_LEN-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [BIT_LEN-1:0] dataInput,
    output logic               wr,
    output logic               wr_clk,
    output logic               newline,
    output logic               cStart,
    input  logic               FULL,
    input  logic               EMPTY,
    input  logic               cReady,
    input  logic [BIT_LEN-1:0] finalsum,
    output logic [BIT_LEN-1:0] res_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               overflow
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int RES_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(OUT_N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [RES_W-1:0] res_cnt;
    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             res_last;

    assign col_last = (col_cnt == COL_LAST);
    assign row_last = (row_cnt == ROW_LAST);
    assign res_last = (res_cnt == RES_LAST);
    assign busy     = (state != ST_IDLE);
    // The FIFO write port runs on the same clock as this block.
    assign wr_clk   = Clk;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        accept     = 1'b0;
        wr         = 1'b0;
        dataInput  = '0;
        newline    = 1'b0;
        cStart     = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready = !FULL;
                accept  = s_valid && !FULL;
                wr      = accept;
                if (accept) dataInput = s_data;
                newline = accept && col_last;
                if (accept && col_last && row_last) state_nxt = ST_START;
            end
            ST_START: begin
                cStart    = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cReady && res_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!res_valid && EMPTY) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
            res_cnt <= '0;
        end else begin
            if (state == ST_IDLE && go) begin
                col_cnt <= '0;
                row_cnt <= '0;
                res_cnt <= '0;
            end
            if (accept) begin
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
            // Dropped results still count so the frame always ends after OUT_N.
            if (state == ST_RUN && cReady && !res_last) res_cnt <= res_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            res_data  <= '0;
            res_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (state == ST_RUN && cReady) begin
                if (!res_valid || res_ready) begin
                    res_data  <= finalsum;
                    res_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if (state == ST_IDLE && go) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_accel_feeder.sv
// tb/tb_conv_accel_feeder.sv - randomized self-checking bench for conv_accel_feeder
module tb_conv_accel_feeder;

    localparam int BIT_LEN = 16;
    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int OUT_N   = 676;
    localparam int NPIX    = IMG_W * IMG_H;

    logic               Clk = 1'b0;
    logic               Rst = 1'b0;
    logic               go = 1'b0;
    logic [BIT_LEN-1:0] s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [BIT_LEN-1:0] dataInput;
    logic               wr;
    logic               wr_clk;
    logic               newline;
    logic               cStart;
    logic               FULL = 1'b0;
    logic               EMPTY = 1'b1;
    logic               cReady = 1'b0;
    logic [BIT_LEN-1:0] finalsum = '0;
    logic [BIT_LEN-1:0] res_data;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic               busy;
    logic               frame_done;
    logic               overflow;

    int checks = 0;
    int failures = 0;
    logic [BIT_LEN-1:0] pix [NPIX];
    logic [BIT_LEN-1:0] popped [$];

    always #5 Clk = ~Clk;

    conv_accel_feeder #(
        .BIT_LEN(BIT_LEN), .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_N(OUT_N)
    ) dut (
        .Clk(Clk), .Rst(Rst), .go(go), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .dataInput(dataInput), .wr(wr), .wr_clk(wr_clk),
        .newline(newline), .cStart(cStart), .FULL(FULL), .EMPTY(EMPTY),
        .cReady(cReady), .finalsum(finalsum), .res_data(res_data),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
        .frame_done(frame_done), .overflow(overflow)
    );

    task automatic fill_pixels(input bit sequential);
        for (int i = 0; i < NPIX; i++) pix[i] = sequential ? BIT_LEN'(i) : BIT_LEN'($urandom);
    endtask

    task automatic start_frame();
        s_valid = 1'b0; cReady = 1'b0; FULL = 1'b0; go = 1'b1;
        @(negedge Clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL start_idle busy=%b want 0", busy); end
        @(posedge Clk); #1;
        go = 1'b0;
    endtask

    // Feeds one frame; pixel index k advances only on accepted words.
    task automatic load_frame(input int stall_at, input int abort_at, input bit gaps);
        int k = 0, cyc = 0, full_left = 0;
        bit stalled = 0, exp_wr;
        while (k < NPIX && cyc < 4000) begin
            if (k == abort_at) begin
                s_valid = 1'b0; Rst = 1'b1;
                @(posedge Clk); #1;
                s_valid = 1'b1;
                @(negedge Clk);
                checks++;
                if ({wr, cStart, busy, s_ready} !== 4'b0000)
                    begin failures++; $display("FAIL abort wr/cStart/busy/s_ready=%b want 0000", {wr, cStart, busy, s_ready}); end
                @(posedge Clk); #1;
                Rst = 1'b0; s_valid = 1'b0;
                return;
            end
            if (k == stall_at && !stalled) begin full_left = 10; stalled = 1; end
            FULL = (full_left > 0);
            s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data = pix[k];
            @(negedge Clk);
            exp_wr = s_valid && !FULL;
            checks++;
            if (s_ready !== !FULL) begin failures++; $display("FAIL load_s_ready k=%0d got=%b want %b", k, s_ready, !FULL); end
            checks++;
            if (wr !== exp_wr) begin failures++; $display("FAIL load_wr k=%0d got=%b want %b", k, wr, exp_wr); end
            checks++;
            if ({cStart, busy, overflow} !== 3'b010)
                begin failures++; $display("FAIL load_status k=%0d cStart/busy/overflow=%b want 010", k, {cStart, busy, overflow}); end
            if (exp_wr) begin
                checks++;
                if (dataInput !== pix[k]) begin failures++; $display("FAIL load_data k=%0d got=%h want %h", k, dataInput, pix[k]); end
                checks++;
                if (newline !== (k % IMG_W == IMG_W - 1)) begin failures++; $display("FAIL newline k=%0d got=%b", k, newline); end
            end
            @(posedge Clk); #1;
            if (full_left > 0) full_left--;
            if (exp_wr) k++;
            cyc++;
        end
        FULL = 1'b0;
        checks++;
        if (k != NPIX) begin failures++; $display("FAIL load_timeout pixels=%0d want %0d", k, NPIX); end
        s_valid = 1'b1;
        @(negedge Clk);
        checks++;
        if ({cStart, wr, s_ready, busy} !== 4'b1001)
            begin failures++; $display("FAIL start_pulse cStart/wr/s_ready/busy=%b want 1001", {cStart, wr, s_ready, busy}); end
        @(posedge Clk); #1;
        s_valid = 1'b0;
        @(negedge Clk);
        checks++;
        if ({cStart, busy} !== 2'b01) begin failures++; $display("FAIL start_once cStart/busy=%b want 01", {cStart, busy}); end
        @(posedge Clk); #1;
    endtask

    // mode 0: cReady every cycle, finalsum=i, res_ready=1; 1: random; 2: first two back-to-back unpopped
    task automatic collect_results(input int mode, input bit go_noise);
        int n = 0, cyc = 0, d;
        bit exp_valid = 0, exp_ov = 0, rr, cr, done = 0;
        logic [BIT_LEN-1:0] exp_data = '0, fs;
        popped.delete();
        while (n < OUT_N && cyc < 20000) begin
            cr = (mode == 0 || (mode == 2 && n < 2)) ? 1'b1 : 1'($urandom_range(0, 1));
            rr = (mode == 0) ? 1'b1 : (mode == 2 && n < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            fs = (mode == 0) ? BIT_LEN'(n) : BIT_LEN'($urandom);
            cReady = cr; res_ready = rr; finalsum = fs; EMPTY = 1'b0;
            go = go_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge Clk);
            checks++;
            if (res_valid !== exp_valid) begin failures++; $display("FAIL res_valid n=%0d got=%b want %b", n, res_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (res_data !== exp_data) begin failures++; $display("FAIL res_data n=%0d got=%h want %h", n, res_data, exp_data); end
            end
            checks++;
            if (overflow !== exp_ov) begin failures++; $display("FAIL overflow n=%0d got=%b want %b", n, overflow, exp_ov); end
            checks++;
            if ({busy, frame_done, wr, cStart} !== 4'b1000)
                begin failures++; $display("FAIL run_status n=%0d busy/frame_done/wr/cStart=%b want 1000", n, {busy, frame_done, wr, cStart}); end
            @(posedge Clk); #1;
            if (exp_valid && rr) popped.push_back(exp_data);
            if (cr) begin
                if (!exp_valid || rr) begin exp_valid = 1; exp_data = fs; end
                else exp_ov = 1;
                n++;
            end else if (exp_valid && rr) begin
                exp_valid = 0;
            end
            cyc++;
        end
        cReady = 1'b0; go = 1'b0;
        checks++;
        if (n != OUT_N) begin failures++; $display("FAIL run_timeout results=%0d want %0d", n, OUT_N); end
        for (d = 0; d < 60 && !done; d++) begin
            EMPTY = (d >= 3);
            rr = (mode == 0 || d >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            res_ready = rr;
            @(negedge Clk);
            checks++;
            if (frame_done !== (!exp_valid && EMPTY))
                begin failures++; $display("FAIL frame_done d=%0d got=%b want %b", d, frame_done, !exp_valid && EMPTY); end
            checks++;
            if (res_valid !== exp_valid || overflow !== exp_ov)
                begin failures++; $display("FAIL drain d=%0d res_valid/overflow=%b%b want %b%b", d, res_valid, overflow, exp_valid, exp_ov); end
            done = !exp_valid && EMPTY;
            @(posedge Clk); #1;
            if (exp_valid && rr) begin popped.push_back(exp_data); exp_valid = 0; end
        end
        checks++;
        if (!done) begin failures++; $display("FAIL drain_timeout frame_done never seen"); end
        @(negedge Clk);
        checks++;
        if ({busy, frame_done, res_valid} !== 3'b000)
            begin failures++; $display("FAIL post_frame busy/frame_done/res_valid=%b want 000", {busy, frame_done, res_valid}); end
        @(posedge Clk); #1;
        res_ready = 1'b0;
        if (mode == 0) begin
            checks++;
            if (popped.size() != OUT_N) begin failures++; $display("FAIL pop_count got=%0d want %0d", popped.size(), OUT_N); end
            for (int i = 0; i < popped.size(); i++) begin
                checks++;
                if (popped[i] !== BIT_LEN'(i)) begin failures++; $display("FAIL pop_seq i=%0d got=%0d want %0d", i, popped[i], i); end
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; s_valid = 1'b1; go = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
        checks++;
        if ({busy, wr, cStart, s_ready, newline, frame_done, res_valid, overflow} !== 8'h00)
            begin failures++; $display("FAIL reset_flags got=%b want 00000000", {busy, wr, cStart, s_ready, newline, frame_done, res_valid, overflow}); end
        checks++;
        if (res_data !== '0 || dataInput !== '0) begin failures++; $display("FAIL reset_data res=%h din=%h want 0", res_data, dataInput); end
        checks++;
        if (wr_clk !== Clk) begin failures++; $display("FAIL wr_clk got=%b want %b", wr_clk, Clk); end
        @(posedge Clk); #1;
        Rst = 1'b0; s_valid = 1'b0;
    endtask

    task automatic test_full_frame();
        fill_pixels(1);
        start_frame();
        load_frame(-1, -1, 0);
        collect_results(0, 0);
    endtask

    task automatic test_fifo_stall();
        fill_pixels(0);
        start_frame();
        load_frame(100, -1, 0);
        collect_results(1, 0);
    endtask

    task automatic test_overflow();
        fill_pixels(0);
        start_frame();
        load_frame(-1, -1, 1);
        collect_results(2, 0);
        start_frame();
        load_frame(-1, -1, 1);
        collect_results(1, 0);
    endtask

    task automatic test_reset_mid_frame();
        fill_pixels(0);
        start_frame();
        load_frame(-1, 400, 0);
        start_frame();
        load_frame(-1, -1, 0);
        collect_results(1, 0);
    endtask

    task automatic test_go_ignored();
        fill_pixels(0);
        start_frame();
        load_frame(-1, -1, 1);
        collect_results(1, 1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            fill_pixels(0);
            start_frame();
            load_frame(int'($urandom_range(0, NPIX - 1)), -1, 1);
            collect_results(1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_fifo_stall();
        test_overflow();
        test_reset_mid_frame();
        test_go_ignored();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
